// File: rtl/ir_prefetch_pkg.sv
// Shared CPU constants and the IR load-source encoding used by ir_prefetch.
package cpu_pkg;

  localparam int CPU_DATA_W = 8;
  localparam int CPU_OPC_W  = 4;
  localparam int IR_DEPTH   = 4;

  // Where the instruction register takes its next word from on a load.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_FIFO   = 2'd1,
    SRC_BYPASS = 2'd2
  } ir_src_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ir_prefetch_if.sv
// Fetch-side handshake and decoder-side outputs of the instruction prefetcher.
import cpu_pkg::*;

interface ir_prefetch_if #(
  parameter int DATA_W = CPU_DATA_W,
  parameter int OPC_W  = CPU_OPC_W,
  parameter int DEPTH  = IR_DEPTH
);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [DATA_W-1:0]       DATA_IN;
  logic                    IN_VALID;
  logic                    IN_READY;
  logic                    ADVANCE;
  logic                    FLUSH;
  logic [DATA_W-1:0]       DATA_OUT;
  logic [OPC_W-1:0]        OPCODE;
  logic [DATA_W-OPC_W-1:0] OPERAND;
  logic                    IR_VALID;
  logic [CNT_W-1:0]        COUNT;

  modport master (
    output DATA_IN, IN_VALID, ADVANCE, FLUSH,
    input  IN_READY, DATA_OUT, OPCODE, OPERAND, IR_VALID, COUNT
  );

  modport slave (
    input  DATA_IN, IN_VALID, ADVANCE, FLUSH,
    output IN_READY, DATA_OUT, OPCODE, OPERAND, IR_VALID, COUNT
  );

endinterface

// File: rtl/ir_prefetch_sync_fifo.sv
// Synchronous FIFO with occupancy counter and a clear input; full/empty come from the count.
import cpu_pkg::*;

module sync_fifo #(
  parameter int DATA_W = CPU_DATA_W,
  parameter int DEPTH  = IR_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  // Storage write; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ir_prefetch.sv
// Instruction register fed by a prefetch FIFO, with an empty-queue bypass and branch flush.
import cpu_pkg::*;

module ir_prefetch #(
  parameter int DATA_W = CPU_DATA_W,
  parameter int OPC_W  = CPU_OPC_W,
  parameter int DEPTH  = IR_DEPTH
) (
  input logic           clk,
  input logic           REST_N,
  ir_prefetch_if.slave  bus
);

  localparam int CNT_W = cnt_width(DEPTH);

  logic [DATA_W-1:0] ir_q;
  logic              ir_valid_q;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              in_ready;
  logic              accept;
  logic              load;
  ir_src_e           src;

  // Ready depends only on the registered count, so ADVANCE never reaches IN_READY.
  assign in_ready = !fifo_full;
  assign accept   = bus.IN_VALID && in_ready;
  assign load     = !ir_valid_q || bus.ADVANCE;

  // Queued words always win over the incoming word so program order is kept.
  always_comb begin
    src = SRC_NONE;
    if (!fifo_empty) begin
      src = SRC_FIFO;
    end else if (accept) begin
      src = SRC_BYPASS;
    end
  end

  // A bypassed word skips the queue; anything accepted during a flush is dropped.
  assign fifo_pop  = load && (src == SRC_FIFO) && !bus.FLUSH;
  assign fifo_push = accept && !bus.FLUSH && !(load && (src == SRC_BYPASS));

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (REST_N),
    .clear   (bus.FLUSH),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (bus.DATA_IN),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Instruction register: flush only invalidates, DATA_OUT keeps its last value.
  always_ff @(posedge clk) begin
    if (!REST_N) begin
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else if (bus.FLUSH) begin
      ir_valid_q <= 1'b0;
    end else if (load) begin
      case (src)
        SRC_FIFO: begin
          ir_q       <= fifo_rd_data;
          ir_valid_q <= 1'b1;
        end
        SRC_BYPASS: begin
          ir_q       <= bus.DATA_IN;
          ir_valid_q <= 1'b1;
        end
        default: ir_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.IN_READY = in_ready;
  assign bus.DATA_OUT = ir_q;
  assign bus.OPCODE   = ir_q[DATA_W-1 -: OPC_W];
  assign bus.OPERAND  = ir_q[DATA_W-OPC_W-1:0];
  assign bus.IR_VALID = ir_valid_q;
  assign bus.COUNT    = fifo_count;

endmodule
